// File: rtl/control_sequencer_if.sv
// Signal bundle between the control sequencer and the datapath/memory it steers.
interface control_sequencer_if;
  logic [31:0] IR_Data;
  logic        mem_ready;
  logic        Gra, Grb, Grc, Rin, Rout, BAout;
  logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Cout;
  logic        Read, Write;
  logic [4:0]  alu_op;
  logic        run, fault;

  modport master (
    input  IR_Data, mem_ready,
    output Gra, Grb, Grc, Rin, Rout, BAout,
    output PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Cout,
    output Read, Write, alu_op, run, fault
  );

  modport slave (
    output IR_Data, mem_ready,
    input  Gra, Grb, Grc, Rin, Rout, BAout,
    input  PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Cout,
    input  Read, Write, alu_op, run, fault
  );
endinterface

// File: rtl/control_sequencer.sv
// Moore control sequencer: fetch/decode/execute strobes with memory-wait timeout.
module control_sequencer #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic                clock,
  input  logic                reset_n,
  control_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT, S_FAULT
  } state_t;

  typedef enum logic [2:0] {
    C_NOP, C_RTYPE, C_ITYPE, C_LD, C_ST, C_HALT
  } cls_t;

  typedef struct packed {
    logic       gra, grb, grc, rin, rout, baout;
    logic       pcout, pcin, incpc, marin, mdrin, mdrout, irin, yin, zin, zlowout, cout;
    logic       read, write;
    logic [4:0] alu_op;
    logic       run, fault;
  } out_t;

  localparam logic [3:0] WAIT_LIM = 4'(WAIT_MAX);

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_HALT = 5'b11011;

  state_t     r_state;
  cls_t       r_cls;
  logic [4:0] r_op;
  logic [3:0] r_cnt;
  logic       r_hold;
  out_t       r_out;

  state_t     w_nxt_state;
  cls_t       w_nxt_cls;
  logic [4:0] w_nxt_op;
  logic [3:0] w_nxt_cnt;
  logic       w_waiting;
  out_t       w_reset_out;
  logic       w_unused_ir;

  assign w_unused_ir = ^bus.IR_Data[26:0];

  function automatic cls_t classify(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: return C_RTYPE;
      OP_ADDI, OP_ANDI, OP_ORI:      return C_ITYPE;
      OP_LD:                         return C_LD;
      OP_ST:                         return C_ST;
      OP_HALT:                       return C_HALT;
      default:                       return C_NOP;
    endcase
  endfunction

  function automatic logic [4:0] imm_alu(input logic [4:0] op);
    case (op)
      OP_ANDI: return OP_AND;
      OP_ORI:  return OP_OR;
      default: return OP_ADD;
    endcase
  endfunction

  function automatic out_t state_outputs(input state_t s, input cls_t c, input logic [4:0] op);
    out_t o;
    o     = '0;
    o.run = 1'b1;
    case (s)
      S_T0: begin o.pcout = 1'b1; o.marin = 1'b1; o.incpc = 1'b1; end
      S_T1: begin o.read = 1'b1; o.mdrin = 1'b1; end
      S_T2: begin o.mdrout = 1'b1; o.irin = 1'b1; end
      S_T3: begin
        if (c == C_RTYPE || c == C_ITYPE) begin
          o.grb = 1'b1; o.rout = 1'b1; o.yin = 1'b1;
        end else if (c == C_LD || c == C_ST) begin
          o.grb = 1'b1; o.baout = 1'b1; o.yin = 1'b1;
        end
      end
      S_T4: begin
        case (c)
          C_RTYPE:    begin o.grc = 1'b1; o.rout = 1'b1; o.zin = 1'b1; o.alu_op = op; end
          C_ITYPE:    begin o.cout = 1'b1; o.zin = 1'b1; o.alu_op = imm_alu(op); end
          C_LD, C_ST: begin o.cout = 1'b1; o.zin = 1'b1; o.alu_op = OP_ADD; end
          default: ;
        endcase
      end
      S_T5: begin
        o.zlowout = 1'b1;
        if (c == C_LD || c == C_ST) o.marin = 1'b1;
        else begin o.gra = 1'b1; o.rin = 1'b1; end
      end
      S_T6: begin
        if (c == C_LD) begin o.read = 1'b1; o.mdrin = 1'b1; end
        else begin o.gra = 1'b1; o.rout = 1'b1; o.mdrin = 1'b1; end
      end
      S_T7: begin
        if (c == C_LD) begin o.mdrout = 1'b1; o.gra = 1'b1; o.rin = 1'b1; end
        else o.write = 1'b1;
      end
      S_HALT:  o.run = 1'b0;
      S_FAULT: begin o.run = 1'b0; o.fault = 1'b1; end
      default: ;
    endcase
    return o;
  endfunction

  always_comb begin
    w_reset_out     = '0;
    w_reset_out.run = 1'b1;
  end

  assign w_waiting = (r_state == S_T1) ||
                     (r_state == S_T6 && r_cls == C_LD) ||
                     (r_state == S_T7 && r_cls == C_ST);

  // The counter defaults to zero, so it is already clear on entry to any wait state.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cls   = r_cls;
    w_nxt_op    = r_op;
    w_nxt_cnt   = '0;
    if (w_waiting && !bus.mem_ready) begin
      if (r_cnt == WAIT_LIM) w_nxt_state = S_FAULT;
      else                   w_nxt_cnt   = r_cnt + 4'd1;
    end else begin
      case (r_state)
        S_T0: w_nxt_state = S_T1;
        S_T1: w_nxt_state = S_T2;
        S_T2: begin
          w_nxt_state = S_T3;
          w_nxt_cls   = classify(bus.IR_Data[31:27]);
          w_nxt_op    = bus.IR_Data[31:27];
        end
        S_T3: begin
          case (r_cls)
            C_NOP:   w_nxt_state = S_T0;
            C_HALT:  w_nxt_state = S_HALT;
            default: w_nxt_state = S_T4;
          endcase
        end
        S_T4: w_nxt_state = S_T5;
        S_T5: w_nxt_state = (r_cls == C_LD || r_cls == C_ST) ? S_T6 : S_T0;
        S_T6: w_nxt_state = S_T7;
        S_T7: w_nxt_state = S_T0;
        S_HALT, S_FAULT: w_nxt_state = r_state;
        default: w_nxt_state = S_T0;
      endcase
    end
  end

  // r_hold keeps T0 for one cycle after release so the first fetch strobes are visible.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= S_T0;
      r_cls   <= C_NOP;
      r_cnt   <= '0;
      r_hold  <= 1'b1;
      r_out   <= w_reset_out;
    end else if (r_hold) begin
      r_hold  <= 1'b0;
      r_out   <= state_outputs(S_T0, r_cls, r_op);
    end else begin
      r_state <= w_nxt_state;
      r_cls   <= w_nxt_cls;
      r_op    <= w_nxt_op;
      r_cnt   <= w_nxt_cnt;
      r_out   <= state_outputs(w_nxt_state, w_nxt_cls, w_nxt_op);
    end
  end

  assign bus.Gra     = r_out.gra;
  assign bus.Grb     = r_out.grb;
  assign bus.Grc     = r_out.grc;
  assign bus.Rin     = r_out.rin;
  assign bus.Rout    = r_out.rout;
  assign bus.BAout   = r_out.baout;
  assign bus.PCout   = r_out.pcout;
  assign bus.PCin    = r_out.pcin;
  assign bus.IncPC   = r_out.incpc;
  assign bus.MARin   = r_out.marin;
  assign bus.MDRin   = r_out.mdrin;
  assign bus.MDRout  = r_out.mdrout;
  assign bus.IRin    = r_out.irin;
  assign bus.Yin     = r_out.yin;
  assign bus.Zin     = r_out.zin;
  assign bus.Zlowout = r_out.zlowout;
  assign bus.Cout    = r_out.cout;
  assign bus.Read    = r_out.read;
  assign bus.Write   = r_out.write;
  assign bus.alu_op  = r_out.alu_op;
  assign bus.run     = r_out.run;
  assign bus.fault   = r_out.fault;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench: an instruction-level model queues per-cycle expected outputs, a monitor compares.
module tb_control_sequencer;
  localparam int WAIT_MAX = 15;

  localparam logic [25:0] GRA     = 26'd1 << 0;
  localparam logic [25:0] GRB     = 26'd1 << 1;
  localparam logic [25:0] GRC     = 26'd1 << 2;
  localparam logic [25:0] RIN     = 26'd1 << 3;
  localparam logic [25:0] ROUT    = 26'd1 << 4;
  localparam logic [25:0] BAOUT   = 26'd1 << 5;
  localparam logic [25:0] PCOUT   = 26'd1 << 6;
  localparam logic [25:0] INCPC   = 26'd1 << 8;
  localparam logic [25:0] MARIN   = 26'd1 << 9;
  localparam logic [25:0] MDRIN   = 26'd1 << 10;
  localparam logic [25:0] MDROUT  = 26'd1 << 11;
  localparam logic [25:0] IRIN    = 26'd1 << 12;
  localparam logic [25:0] YIN     = 26'd1 << 13;
  localparam logic [25:0] ZIN     = 26'd1 << 14;
  localparam logic [25:0] ZLOWOUT = 26'd1 << 15;
  localparam logic [25:0] COUT    = 26'd1 << 16;
  localparam logic [25:0] READ    = 26'd1 << 17;
  localparam logic [25:0] WRITE   = 26'd1 << 18;
  localparam logic [25:0] RUN     = 26'd1 << 24;
  localparam logic [25:0] FLT     = 26'd1 << 25;
  localparam logic [25:0] RSTV    = RUN;

  localparam int K_NOP = 0, K_R = 1, K_I = 2, K_LD = 3, K_ST = 4, K_HALT = 5;

  typedef struct {
    logic [25:0] exp;
    string       tag;
  } sb_t;

  logic clk = 1'b0;
  logic reset_n;
  int   n_vec = 0;
  int   n_err = 0;
  sb_t  sb[$];
  logic [25:0] act;

  control_sequencer_if bus();

  control_sequencer #(.WAIT_MAX(WAIT_MAX)) dut (
    .clock   (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  always #5 clk = ~clk;

  assign act = {bus.fault, bus.run, bus.alu_op, bus.Write, bus.Read, bus.Cout, bus.Zlowout,
                bus.Zin, bus.Yin, bus.IRin, bus.MDRout, bus.MDRin, bus.MARin, bus.IncPC,
                bus.PCin, bus.PCout, bus.BAout, bus.Rout, bus.Rin, bus.Grc, bus.Grb, bus.Gra};

  function automatic logic [25:0] alu(input logic [4:0] op);
    return 26'(op) << 19;
  endfunction

  function automatic int kind_of(input logic [4:0] op);
    case (op)
      5'd3, 5'd4, 5'd5, 5'd6: return K_R;
      5'd12, 5'd13, 5'd14:    return K_I;
      5'd0:                   return K_LD;
      5'd2:                   return K_ST;
      5'd27:                  return K_HALT;
      default:                return K_NOP;
    endcase
  endfunction

  function automatic logic rmr();
    return 1'($urandom);
  endfunction

  // One clock cycle: record what the DUT must show now, then drive this cycle's inputs.
  task automatic step(input logic [25:0] exp, input string tag, input logic mr,
                      input logic rn, input logic [31:0] ir);
    sb_t e;
    @(posedge clk);
    #1;
    e.exp = exp;
    e.tag = tag;
    sb.push_back(e);
    bus.mem_ready = mr;
    reset_n       = rn;
    bus.IR_Data   = ir;
  endtask

  task automatic reset_pulse(input logic [25:0] cur, input string tag, input int hold);
    step(cur, tag, rmr(), 1'b0, $urandom);
    for (int k = 0; k < hold; k++) step(RSTV, "RESET", rmr(), 1'b0, $urandom);
    step(RSTV, "RESET", rmr(), 1'b1, $urandom);
  endtask

  task automatic fault_tail();
    for (int k = 0; k < 4; k++) step(FLT, "FAULT", rmr(), 1'b1, $urandom);
    reset_pulse(FLT, "FAULT", 1);
  endtask

  // A memory access: d cycles of mem_ready=0 then completion, or timeout after WAIT_MAX+1.
  task automatic wait_phase(input logic [25:0] v, input string tag, input int d, output bit ok);
    if (d > WAIT_MAX) begin
      for (int k = 0; k <= WAIT_MAX; k++) step(v, tag, 1'b0, 1'b1, $urandom);
      ok = 1'b0;
    end else begin
      for (int k = 0; k < d; k++) step(v, tag, 1'b0, 1'b1, $urandom);
      step(v, tag, 1'b1, 1'b1, $urandom);
      ok = 1'b1;
    end
  endtask

  task automatic do_instr(input logic [4:0] op, input int d1, input int d2, input bit abort_t6);
    logic [31:0] ir;
    logic [25:0] t3v;
    logic [4:0]  iop;
    bit          ok;
    int          k;
    ir = {op, 27'($urandom)};
    k  = kind_of(op);
    step(RUN | PCOUT | MARIN | INCPC, "T0", rmr(), 1'b1, $urandom);
    wait_phase(RUN | READ | MDRIN, "T1", d1, ok);
    if (!ok) begin fault_tail(); return; end
    step(RUN | MDROUT | IRIN, "T2", rmr(), 1'b1, ir);
    if (k == K_R || k == K_I)        t3v = GRB | ROUT | YIN;
    else if (k == K_LD || k == K_ST) t3v = GRB | BAOUT | YIN;
    else                             t3v = '0;
    step(RUN | t3v, "T3", rmr(), 1'b1, ir);
    if (k == K_NOP) return;
    if (k == K_HALT) begin
      for (int c = 0; c < 19; c++) step('0, "HALT", rmr(), 1'b1, $urandom);
      reset_pulse('0, "HALT", 0);
      return;
    end
    iop = (op == 5'd13) ? 5'd5 : (op == 5'd14) ? 5'd6 : 5'd3;
    if (k == K_R)      step(RUN | GRC | ROUT | ZIN | alu(op), "T4", rmr(), 1'b1, $urandom);
    else if (k == K_I) step(RUN | COUT | ZIN | alu(iop), "T4", rmr(), 1'b1, $urandom);
    else               step(RUN | COUT | ZIN | alu(5'd3), "T4", rmr(), 1'b1, $urandom);
    if (k == K_R || k == K_I) begin
      step(RUN | ZLOWOUT | GRA | RIN, "T5", rmr(), 1'b1, $urandom);
      return;
    end
    step(RUN | ZLOWOUT | MARIN, "T5", rmr(), 1'b1, $urandom);
    if (k == K_LD) begin
      if (abort_t6) begin reset_pulse(RUN | READ | MDRIN, "T6", 0); return; end
      wait_phase(RUN | READ | MDRIN, "T6", d2, ok);
      if (!ok) begin fault_tail(); return; end
      step(RUN | MDROUT | GRA | RIN, "T7", rmr(), 1'b1, $urandom);
    end else begin
      step(RUN | GRA | ROUT | MDRIN, "T6", rmr(), 1'b1, $urandom);
      wait_phase(RUN | WRITE, "T7", d2, ok);
      if (!ok) fault_tail();
    end
  endtask

  initial begin : monitor
    sb_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_vec++;
        if (act !== e.exp) begin
          n_err++;
          $display("FAIL %s @%0t: outputs got %h, expected %h", e.tag, $time, act, e.exp);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d vectors checked", n_vec);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [4:0] ops [12];
    logic [4:0] op;
    int         idx;
    ops = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd12, 5'd13, 5'd14, 5'd0, 5'd2, 5'd27, 5'd31, 5'd0};
    bus.IR_Data   = '0;
    bus.mem_ready = 1'b0;
    reset_n       = 1'b0;
    step(RSTV, "RESET", 1'b0, 1'b0, '0);
    step(RSTV, "RESET", 1'b0, 1'b1, '0);

    do_instr(5'b00011, 0, 0, 1'b0);
    do_instr(5'b00000, 3, 3, 1'b0);
    do_instr(5'b00010, 1, 2, 1'b0);
    do_instr(5'b11111, 0, 0, 1'b0);
    do_instr(5'b00000, 1, 2, 1'b1);
    do_instr(5'b11011, 0, 0, 1'b0);
    do_instr(5'b01101, WAIT_MAX, 0, 1'b0);
    do_instr(5'b00011, WAIT_MAX + 1, 0, 1'b0);
    do_instr(5'b00000, 0, WAIT_MAX + 1, 1'b0);
    do_instr(5'b00010, 0, WAIT_MAX + 1, 1'b0);

    for (int n = 0; n < 40; n++) begin
      idx = $urandom_range(0, 11);
      op  = (idx == 11) ? 5'($urandom) : ops[idx];
      do_instr(op, $urandom_range(0, 4), $urandom_range(0, 4), ($urandom_range(0, 9) == 0));
    end
    do_instr(5'b00100, 0, 0, 1'b0);

    repeat (3) @(posedge clk);
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected vectors left unchecked, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
